d_mem_latency_responder: RTL and testbench
==========================================

D_MEM_LATENCY_RESPONDER -- requirements
Module: d_mem_latency_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDRESS_BITS, default 32, request/response address width.
REQ-003 SHALL have parameter MEM_ADDRESS_BITS, default 10, log2 of word count of internal array.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-005 SHALL have port clock, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port d_mem_read, input, 1, read request.
REQ-008 SHALL have port d_mem_write, input, 1, write request.
REQ-009 SHALL have port d_mem_byte_en, input, DATA_WIDTH/8, per-byte write enable.
REQ-010 SHALL have port d_mem_address_in, input, ADDRESS_BITS, byte address of request.
REQ-011 SHALL have port d_mem_data_in, input, DATA_WIDTH, write data.
REQ-012 SHALL have port d_mem_data_out, output, DATA_WIDTH, response data.
REQ-013 SHALL have port d_mem_address_out, output, ADDRESS_BITS, address of request being answered.
REQ-014 SHALL have port d_mem_valid, output, 1, one-cycle response strobe.
REQ-015 SHALL have port d_mem_ready, output, 1, responder can accept a request this cycle.
REQ-016 SHALL have port scan, input, 1, debug trace enable; no functional effect.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESPOND; d_mem_ready = 1 in IDLE and RESPOND, 0 in BUSY.
REQ-018 SHALL accept a request in cycle N when d_mem_ready && (d_mem_read || d_mem_write), capturing address, data, byte_en, read/write kind.
REQ-019 SHALL assert d_mem_valid for exactly one cycle, cycle N+LATENCY, with d_mem_address_out = captured address.
REQ-020 SHALL transition on acceptance to BUSY with down-counter = LATENCY-1, or directly to RESPOND when LATENCY = 1.
REQ-021 SHALL decrement counter each BUSY cycle, entering RESPOND when it reaches 0 after the decrement.
REQ-022 SHALL in RESPOND return to IDLE unless a new request is accepted that same cycle (back-to-back), in which case behave per REQ-020.
REQ-023 SHALL index the array with d_mem_address_in[MEM_ADDRESS_BITS+1:2]; upper address bits ignored (aliasing wrap), low two bits ignored.
REQ-024 SHALL commit a write at the acceptance edge, updating only bytes whose byte_en bit is 1; byte_en = 0 is a legal no-op write that still produces a response.
REQ-025 SHALL on read response drive d_mem_data_out = array word as of the acceptance edge.
REQ-026 SHALL on write response drive d_mem_data_out = merged word after the write.
REQ-027 SHALL treat d_mem_read && d_mem_write together as a write (REQ-026 applies).
REQ-028 SHALL ignore requests while d_mem_ready = 0; no queueing, requester must hold or re-issue.
REQ-029 SHALL hold d_mem_data_out and d_mem_address_out stable from one response until the next response.
REQ-030 SHALL make a read accepted immediately after a write to the same word return the written data.

Reset
REQ-031 SHALL, while reset = 0, force state IDLE, counter 0, d_mem_valid 0, d_mem_ready 0, d_mem_data_out 0, d_mem_address_out 0.
REQ-032 SHALL assert d_mem_ready = 1 in the first cycle after reset deasserts.
REQ-033 SHALL drop any in-flight request on reset mid-operation with no d_mem_valid; writes already committed remain.
REQ-034 SHALL not clear the memory array on reset.

Verification
REQ-035 LATENCY=2: write 0xDEADBEEF, byte_en 4'hF, addr 0x10 at cycle N -> valid only at N+2, address_out 0x10, data_out 0xDEADBEEF, ready 0 at N+1.
REQ-036 After REQ-035: write 0x000000AA byte_en 4'b0001 addr 0x10, then read 0x10 -> read data_out 0xDEADBEAA.
REQ-037 MEM_ADDRESS_BITS=10: write 0x12345678 to 0x0, read 0x1000 -> data_out 0x12345678 (alias), address_out 0x1000.
REQ-038 Back-to-back: new read presented in RESPOND cycle -> accepted, next valid exactly LATENCY cycles later; read asserted during BUSY -> ignored, no extra valid.
REQ-039 Reset pulled low in BUSY after read accepted -> no valid, outputs 0, ready 1 in first cycle after release; earlier write data still readable.
REQ-040 LATENCY=1: read and write asserted together with data 0x55 byte_en 4'hF -> valid next cycle, data_out 0x00000055, ready never low.

Source files
------------

// File: rtl/d_mem_latency_responder.sv
// d_mem_latency_responder
//   Single-port word memory behind a fixed-latency request/response handshake.
//   A request is accepted when ready is high and read or write is asserted.
//   Exactly LATENCY cycles after acceptance, valid pulses for one cycle. During
//   that cycle the captured address and the response word are presented.
//   Writes commit at the acceptance edge.
//
// Ports
//   clock             : rising-edge clock
//   reset             : asynchronous active-low reset
//   d_mem_read        : read request
//   d_mem_write       : write request (wins when asserted together with read)
//   d_mem_byte_en     : per-byte write enable
//   d_mem_address_in  : byte address; word index is [MEM_ADDRESS_BITS+1:2]
//   d_mem_data_in     : write data
//   d_mem_data_out    : response data (held until the next response)
//   d_mem_address_out : address of the request being answered (held likewise)
//   d_mem_valid       : one-cycle response strobe
//   d_mem_ready       : a request can be accepted this cycle
//   scan              : debug trace enable, no functional effect
module d_mem_latency_responder #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 10,
  parameter int LATENCY          = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  output logic                      d_mem_valid,
  output logic                      d_mem_ready,
  input  logic                      scan
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << MEM_ADDRESS_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                count_q, count_d;
  logic                      ready_q;
  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     data_out_q;
  logic [ADDRESS_BITS-1:0]   addr_out_q;
  logic [DATA_WIDTH-1:0]     pend_data_q;
  logic [ADDRESS_BITS-1:0]   pend_addr_q;

  logic [DATA_WIDTH-1:0]     mem_q [0:DEPTH-1];

  logic                      accept;
  logic [MEM_ADDRESS_BITS-1:0] idx;
  logic [DATA_WIDTH-1:0]     cur_word;
  logic [DATA_WIDTH-1:0]     resp_word;

  // scan and the ignored address bits have no functional effect
  logic unused_ok;
  assign unused_ok = ^{scan, d_mem_address_in};

  assign accept   = ready_q & (d_mem_read | d_mem_write);
  assign idx      = d_mem_address_in[MEM_ADDRESS_BITS+1:2];
  assign cur_word = mem_q[idx];

  // Response word: the stored word for a read, the byte-merged word for a write.
  // The same value is what gets written back, so a write response always
  // matches the array contents after the commit.
  always_comb begin
    resp_word = cur_word;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (d_mem_write && d_mem_byte_en[b]) begin
        resp_word[b*8 +: 8] = d_mem_data_in[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE, RESPOND: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESPOND;
            count_d = '0;
          end else begin
            state_d = BUSY;
            count_d = 4'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      BUSY: begin
        count_d = count_q - 4'd1;
        if (count_d == '0) begin
          state_d = RESPOND;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_out_q  <= '0;
      addr_out_q  <= '0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= (state_d != BUSY);
      valid_q <= (state_d == RESPOND);
      if (accept) begin
        pend_data_q <= resp_word;
        pend_addr_q <= d_mem_address_in;
      end
      // Entering RESPOND straight from acceptance only happens at LATENCY 1,
      // so the response bypasses the pending registers in that case.
      if (state_d == RESPOND) begin
        data_out_q <= accept ? resp_word : pend_data_q;
        addr_out_q <= accept ? d_mem_address_in : pend_addr_q;
      end
    end
  end

  // Array is intentionally not reset; committed writes survive a reset.
  always_ff @(posedge clock) begin
    if (accept && d_mem_write) begin
      mem_q[idx] <= resp_word;
    end
  end

  assign d_mem_ready       = ready_q;
  assign d_mem_valid       = valid_q;
  assign d_mem_data_out    = data_out_q;
  assign d_mem_address_out = addr_out_q;

endmodule

// File: tb/tb_d_mem_latency_responder.sv
module tb_d_mem_latency_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic scan;

  logic        rd2, wr2;
  logic [3:0]  be2;
  logic [31:0] ain2, din2;
  logic [31:0] dout2, aout2;
  logic        valid2, ready2;

  logic        rd1, wr1;
  logic [3:0]  be1;
  logic [31:0] ain1, din1;
  logic [31:0] dout1, aout1;
  logic        valid1, ready1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q2[$];
  resp_t       exp_q1[$];
  logic [31:0] model2 [int unsigned];
  logic [31:0] model1 [int unsigned];

  int tests = 0;
  int fails = 0;

  d_mem_latency_responder #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(10), .LATENCY(2)
  ) u_dut2 (
    .clock(clk), .reset(rst_n),
    .d_mem_read(rd2), .d_mem_write(wr2), .d_mem_byte_en(be2),
    .d_mem_address_in(ain2), .d_mem_data_in(din2),
    .d_mem_data_out(dout2), .d_mem_address_out(aout2),
    .d_mem_valid(valid2), .d_mem_ready(ready2), .scan(scan)
  );

  d_mem_latency_responder #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(10), .LATENCY(1)
  ) u_dut1 (
    .clock(clk), .reset(rst_n),
    .d_mem_read(rd1), .d_mem_write(wr1), .d_mem_byte_en(be1),
    .d_mem_address_in(ain1), .d_mem_data_in(din1),
    .d_mem_data_out(dout1), .d_mem_address_out(aout1),
    .d_mem_valid(valid1), .d_mem_ready(ready1), .scan(scan)
  );

  // Reference memory: word index is address bits [11:2], unwritten words read 0
  function automatic resp_t model_access(input bit on1, input logic wr, input logic [3:0] be,
                                         input logic [31:0] addr, input logic [31:0] data);
    resp_t       r;
    logic [31:0] w;
    int unsigned idx;
    idx = int'(addr[11:2]);
    if (on1) w = model1.exists(idx) ? model1[idx] : 32'h0;
    else     w = model2.exists(idx) ? model2[idx] : 32'h0;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) w[b*8 +: 8] = data[b*8 +: 8];
      if (on1) model1[idx] = w;
      else     model2[idx] = w;
    end
    r.addr = addr;
    r.data = w;
    return r;
  endfunction

  function automatic resp_t pop2();
    resp_t r;
    r.addr = 32'hxxxxxxxx;
    r.data = 32'hxxxxxxxx;
    if (exp_q2.size() > 0) r = exp_q2.pop_front();
    return r;
  endfunction

  function automatic resp_t pop1();
    resp_t r;
    r.addr = 32'hxxxxxxxx;
    r.data = 32'hxxxxxxxx;
    if (exp_q1.size() > 0) r = exp_q1.pop_front();
    return r;
  endfunction

  // Present one request to the LATENCY=2 unit for one cycle; returns one cycle later
  task automatic drive2(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] data);
    rd2 = rd; wr2 = wr; be2 = be; ain2 = addr; din2 = data;
    exp_q2.push_back(model_access(1'b0, wr, be, addr, data));
    @(negedge clk);
    rd2 = 1'b0; wr2 = 1'b0; be2 = '0;
  endtask

  // Steps negedges until valid2 is seen; k is the cycle offset from acceptance, -1 on timeout
  task automatic wait_valid2(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      if (valid2 === 1'b1) begin
        k = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", valid2); end
    tests++; if (ready2 !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b expected 0", ready2); end
    tests++; if (dout2 !== 32'h0) begin fails++; $display("FAIL rst_data: got %h expected 00000000", dout2); end
    tests++; if (aout2 !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h expected 00000000", aout2); end
    tests++; if (ready1 !== 1'b0) begin fails++; $display("FAIL rst_ready_l1: got %b expected 0", ready1); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (ready2 !== 1'b1) begin fails++; $display("FAIL rel_ready: got %b expected 1", ready2); end
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL rel_ready_l1: got %b expected 1", ready1); end
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL rel_valid: got %b expected 0", valid2); end
  endtask

  task automatic test_write_latency();
    resp_t e;
    tests++; if (ready2 !== 1'b1) begin fails++; $display("FAIL wl_ready_n: got %b expected 1", ready2); end
    rd2 = 1'b0; wr2 = 1'b1; be2 = 4'hF; ain2 = 32'h10; din2 = 32'hDEADBEEF;
    exp_q2.push_back(model_access(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF));
    @(negedge clk);
    wr2 = 1'b0; be2 = '0;
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL wl_valid_n1: got %b expected 0", valid2); end
    tests++; if (ready2 !== 1'b0) begin fails++; $display("FAIL wl_ready_n1: got %b expected 0", ready2); end
    @(negedge clk);
    e = pop2();
    tests++; if (valid2 !== 1'b1) begin fails++; $display("FAIL wl_valid_n2: got %b expected 1", valid2); end
    tests++; if (aout2 !== e.addr) begin fails++; $display("FAIL wl_addr: got %h expected %h", aout2, e.addr); end
    tests++; if (dout2 !== 32'hDEADBEEF) begin fails++; $display("FAIL wl_data: got %h expected deadbeef", dout2); end
    tests++; if (ready2 !== 1'b1) begin fails++; $display("FAIL wl_ready_n2: got %b expected 1", ready2); end
    @(negedge clk);
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL wl_valid_n3: got %b expected 0", valid2); end
    tests++; if (dout2 !== 32'hDEADBEEF) begin fails++; $display("FAIL wl_hold: got %h expected deadbeef", dout2); end
  endtask

  task automatic test_byte_merge();
    resp_t e;
    int    k;
    drive2(1'b0, 1'b1, 4'b0001, 32'h10, 32'h000000AA);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (k !== 2) begin fails++; $display("FAIL bm_wr_lat: got %0d expected 2", k); end
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL bm_wr_data: got %h expected %h", dout2, e.data); end
    @(negedge clk);
    drive2(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (k !== 2) begin fails++; $display("FAIL bm_rd_lat: got %0d expected 2", k); end
    tests++; if (dout2 !== 32'hDEADBEAA) begin fails++; $display("FAIL bm_rd_data: got %h expected deadbeaa", dout2); end
    tests++; if (aout2 !== e.addr) begin fails++; $display("FAIL bm_rd_addr: got %h expected %h", aout2, e.addr); end
    @(negedge clk);
    // byte_en = 0 still answers, with the word unchanged
    drive2(1'b0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (k !== 2) begin fails++; $display("FAIL noop_lat: got %0d expected 2", k); end
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL noop_data: got %h expected %h", dout2, e.data); end
    @(negedge clk);
  endtask

  task automatic test_alias();
    resp_t e;
    int    k;
    drive2(1'b0, 1'b1, 4'hF, 32'h0, 32'h12345678);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL al_wr_data: got %h expected %h", dout2, e.data); end
    @(negedge clk);
    drive2(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (k !== 2) begin fails++; $display("FAIL al_lat: got %0d expected 2", k); end
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL al_data: got %h expected %h", dout2, e.data); end
    tests++; if (aout2 !== 32'h1000) begin fails++; $display("FAIL al_addr: got %h expected 00001000", aout2); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    resp_t e;
    rd2 = 1'b1; ain2 = 32'h10;
    exp_q2.push_back(model_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0));
    @(negedge clk);
    // BUSY: this request must be ignored
    ain2 = 32'h0;
    tests++; if (ready2 !== 1'b0) begin fails++; $display("FAIL b2b_busy_ready: got %b expected 0", ready2); end
    @(negedge clk);
    e = pop2();
    tests++; if (valid2 !== 1'b1) begin fails++; $display("FAIL b2b_valid1: got %b expected 1", valid2); end
    tests++; if (aout2 !== e.addr) begin fails++; $display("FAIL b2b_addr1: got %h expected %h", aout2, e.addr); end
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL b2b_data1: got %h expected %h", dout2, e.data); end
    tests++; if (ready2 !== 1'b1) begin fails++; $display("FAIL b2b_resp_ready: got %b expected 1", ready2); end
    ain2 = 32'h1000;
    exp_q2.push_back(model_access(1'b0, 1'b0, 4'h0, 32'h1000, 32'h0));
    @(negedge clk);
    rd2 = 1'b0;
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b expected 0", valid2); end
    @(negedge clk);
    e = pop2();
    tests++; if (valid2 !== 1'b1) begin fails++; $display("FAIL b2b_valid2: got %b expected 1", valid2); end
    tests++; if (aout2 !== e.addr) begin fails++; $display("FAIL b2b_addr2: got %h expected %h", aout2, e.addr); end
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL b2b_data2: got %h expected %h", dout2, e.data); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL b2b_extra_valid: got %b expected 0 at %0d", valid2, i); end
    end
  endtask

  task automatic test_raw();
    resp_t e;
    int    k;
    drive2(1'b0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL raw_wr_data: got %h expected %h", dout2, e.data); end
    drive2(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (k !== 2) begin fails++; $display("FAIL raw_lat: got %0d expected 2", k); end
    tests++; if (dout2 !== 32'hCAFEF00D) begin fails++; $display("FAIL raw_data: got %h expected cafef00d", dout2); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    resp_t e;
    int    k;
    rd2 = 1'b1; ain2 = 32'h10;
    @(negedge clk);
    rd2 = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL mr_valid: got %b expected 0", valid2); end
    tests++; if (ready2 !== 1'b0) begin fails++; $display("FAIL mr_ready: got %b expected 0", ready2); end
    tests++; if (dout2 !== 32'h0) begin fails++; $display("FAIL mr_data: got %h expected 00000000", dout2); end
    tests++; if (aout2 !== 32'h0) begin fails++; $display("FAIL mr_addr: got %h expected 00000000", aout2); end
    @(negedge clk);
    @(negedge clk);
    tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL mr_valid_hold: got %b expected 0", valid2); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (ready2 !== 1'b1) begin fails++; $display("FAIL mr_rel_ready: got %b expected 1", ready2); end
    tests++; if (dout2 !== 32'h0) begin fails++; $display("FAIL mr_rel_data: got %h expected 00000000", dout2); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL mr_stale_valid: got %b expected 0 at %0d", valid2, i); end
      @(negedge clk);
    end
    drive2(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    wait_valid2(8, k);
    e = pop2();
    tests++; if (k !== 2) begin fails++; $display("FAIL mr_rd_lat: got %0d expected 2", k); end
    tests++; if (dout2 !== 32'hDEADBEAA) begin fails++; $display("FAIL mr_rd_data: got %h expected deadbeaa", dout2); end
    tests++; if (dout2 !== e.data) begin fails++; $display("FAIL mr_rd_model: got %h expected %h", dout2, e.data); end
    @(negedge clk);
  endtask

  task automatic test_latency1();
    resp_t e;
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL l1_ready0: got %b expected 1", ready1); end
    rd1 = 1'b1; wr1 = 1'b1; be1 = 4'hF; ain1 = 32'h40; din1 = 32'h55;
    exp_q1.push_back(model_access(1'b1, 1'b1, 4'hF, 32'h40, 32'h55));
    @(negedge clk);
    e = pop1();
    tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL l1_valid: got %b expected 1", valid1); end
    tests++; if (dout1 !== 32'h00000055) begin fails++; $display("FAIL l1_data: got %h expected 00000055", dout1); end
    tests++; if (aout1 !== e.addr) begin fails++; $display("FAIL l1_addr: got %h expected %h", aout1, e.addr); end
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL l1_ready1: got %b expected 1", ready1); end
    wr1 = 1'b0; be1 = '0; din1 = 32'h0;
    exp_q1.push_back(model_access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0));
    @(negedge clk);
    rd1 = 1'b0;
    e = pop1();
    tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL l1_b2b_valid: got %b expected 1", valid1); end
    tests++; if (dout1 !== e.data) begin fails++; $display("FAIL l1_b2b_data: got %h expected %h", dout1, e.data); end
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL l1_ready2: got %b expected 1", ready1); end
    @(negedge clk);
    tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL l1_valid_end: got %b expected 0", valid1); end
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL l1_ready3: got %b expected 1", ready1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; scan = 1'b0;
    rd2 = 1'b0; wr2 = 1'b0; be2 = '0; ain2 = '0; din2 = '0;
    rd1 = 1'b0; wr1 = 1'b0; be1 = '0; ain1 = '0; din1 = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_write_latency();
    test_byte_merge();
    test_alias();
    test_back_to_back();
    test_raw();
    test_reset_midflight();
    test_latency1();
    tests++; if (exp_q2.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d expected 0", exp_q2.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
